seq_detector_param: RTL

//  Parametrised serial bit-sequence detector. It replaces fixed hard-coded pattern FSMs.
//  The pattern is programmable and LEN bits long, with a per-bit don't-care mask and a

---
 rtl/seq_detector_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_detector_param : programmable serial pattern detector with mask,      |
// | overlap mode, registered match pulse and saturating match counter.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seq_detector_param #(
   parameter int LEN     = 4,
   parameter int COUNT_W = 8
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_load,
   input  logic [LEN-1:0]             i_pattern,
   input  logic [LEN-1:0]             i_mask,
   input  logic                       i_overlap,
   input  logic                       i_start,
   input  logic                       i_stop,
   input  logic                       i_din,
   input  logic                       i_din_valid,
   output logic                       o_match,
   output logic [COUNT_W-1:0]         o_match_count,
   output logic                       o_count_sat,
   output logic [1:0]                 o_state,
   output logic [$clog2(LEN+1)-1:0]   o_fill
);

   localparam int FW = $clog2(LEN+1);
   localparam logic [FW-1:0] c_LEN_F = FW'(LEN);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_FILL   = 2'b01,
      S_SEARCH = 2'b10
   } state_t;

   state_t             r_state,   w_state_n;
   logic [FW-1:0]      r_fill,    w_fill_n;
   logic [LEN-1:0]     r_hist,    w_hist_n;
   logic               r_match,   w_match_n;
   logic [COUNT_W-1:0] r_count,   w_count_n;
   logic               r_sat,     w_sat_n;
   logic [LEN-1:0]     r_pat,     w_pat_n;
   logic [LEN-1:0]     r_mask,    w_mask_n;
   logic               r_ovl,     w_ovl_n;

   logic [LEN-1:0]     w_hist_sh;
   logic [FW-1:0]      w_fill_inc;
   logic               w_armed;
   logic               w_hit;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_fill  <= '0;
         r_hist  <= '0;
         r_match <= 1'b0;
         r_count <= '0;
         r_sat   <= 1'b0;
         r_pat   <= '0;
         r_mask  <= '1;
         r_ovl   <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_fill  <= w_fill_n;
         r_hist  <= w_hist_n;
         r_match <= w_match_n;
         r_count <= w_count_n;
         r_sat   <= w_sat_n;
         r_pat   <= w_pat_n;
         r_mask  <= w_mask_n;
         r_ovl   <= w_ovl_n;
      end
   end

   // Candidate history/fill for the bit on i_din, used only when it is accepted.
   assign w_hist_sh  = {r_hist[LEN-2:0], i_din};
   assign w_fill_inc = (r_fill == c_LEN_F) ? c_LEN_F : r_fill + FW'(1);
   assign w_armed    = (r_state == S_FILL) || (r_state == S_SEARCH);
   assign w_hit      = (w_fill_inc == c_LEN_F) &&
                       (((w_hist_sh ^ r_pat) & r_mask) == '0);

   always_comb begin
      w_state_n = r_state;
      w_fill_n  = r_fill;
      w_hist_n  = r_hist;
      w_match_n = 1'b0;
      w_count_n = r_count;
      w_sat_n   = r_sat;
      w_pat_n   = r_pat;
      w_mask_n  = r_mask;
      w_ovl_n   = r_ovl;

      if (i_load) begin
         w_pat_n   = i_pattern;
         w_mask_n  = i_mask;
         w_ovl_n   = i_overlap;
         w_hist_n  = '0;
         w_fill_n  = '0;
         w_count_n = '0;
         w_sat_n   = 1'b0;
         w_state_n = S_IDLE;
      end else if (i_stop) begin
         w_state_n = S_IDLE;
         w_fill_n  = '0;
      end else if (i_start && (r_state == S_IDLE)) begin
         w_state_n = S_FILL;
         w_fill_n  = '0;
      end else if (!w_armed) begin
         // Covers IDLE and the unused 2'b11 encoding.
         w_state_n = S_IDLE;
      end else if (i_din_valid) begin
         w_hist_n  = w_hist_sh;
         w_match_n = w_hit;
         if (w_hit && !r_ovl) begin
            w_fill_n  = '0;
            w_state_n = S_FILL;
         end else begin
            w_fill_n  = w_fill_inc;
            w_state_n = (w_fill_inc == c_LEN_F) ? S_SEARCH : S_FILL;
         end
         if (w_hit && (r_count != '1)) begin
            w_count_n = r_count + COUNT_W'(1);
            if (w_count_n == '1) begin
               w_sat_n = 1'b1;
            end
         end
      end
   end

   assign o_match       = r_match;
   assign o_match_count = r_count;
   assign o_count_sat   = r_sat;
   assign o_state       = r_state;
   assign o_fill        = r_fill;

endmodule
`default_nettype wire
